// File: rtl/fb_write_arbiter.sv
// Single write port of the frame-buffer RAM: arbitrates capture pixels, the full-buffer
// clear sweep and overlay writes, presenting one registered write per dot clock.
module fb_write_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int FB_DEPTH = 192000,
  parameter int DROP_W   = 8
) (
  input  logic              i_dotclk,
  input  logic              i_reset,
  input  logic              i_pix_valid,
  input  logic [ADDR_W-1:0] i_pix_addr,
  input  logic              i_pix_data,
  input  logic              i_clear_req,
  input  logic              i_ovl_req,
  input  logic [ADDR_W-1:0] i_ovl_addr,
  input  logic              i_ovl_data,
  output logic              o_ovl_ack,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_wdata,
  output logic              o_wren,
  output logic              o_clear_busy,
  output logic              o_clear_done,
  output logic [DROP_W-1:0] o_drop_cnt
);

  typedef enum logic [1:0] {NORMAL, CLEAR, DONE} state_t;

  // Compare against the last valid address so FB_DEPTH == 2^ADDR_W does not wrap.
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n, waddr_n;
  logic              wdata_n, wren_n, ack_n, done_n, busy_n, drop_inc;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    waddr_n  = o_waddr;
    wdata_n  = o_wdata;
    wren_n   = 1'b0;
    ack_n    = 1'b0;
    done_n   = 1'b0;
    drop_inc = 1'b0;
    case (state)
      NORMAL: begin
        if (i_clear_req) begin
          state_n  = CLEAR;
          cnt_n    = '0;
          drop_inc = i_pix_valid;
        end else if (i_pix_valid) begin
          if (i_pix_addr <= LAST) begin
            waddr_n = i_pix_addr;
            wdata_n = i_pix_data;
            wren_n  = 1'b1;
          end else begin
            drop_inc = 1'b1;
          end
        end else if (i_ovl_req && !o_ovl_ack) begin
          // Skipping the cycle after an ack lets the requester drop its request.
          ack_n = 1'b1;
          if (i_ovl_addr <= LAST) begin
            waddr_n = i_ovl_addr;
            wdata_n = i_ovl_data;
            wren_n  = 1'b1;
          end
        end
      end
      CLEAR: begin
        waddr_n  = cnt;
        wdata_n  = 1'b0;
        wren_n   = 1'b1;
        drop_inc = i_pix_valid;
        if (i_clear_req)      cnt_n   = '0;
        else if (cnt == LAST) state_n = DONE;
        else                  cnt_n   = cnt + 1'b1;
      end
      DONE: begin
        drop_inc = i_pix_valid;
        if (i_clear_req) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end else begin
          state_n = NORMAL;
          done_n  = 1'b1;
        end
      end
      default: state_n = NORMAL;
    endcase
    // Busy spans every registered clear write, including a restart out of DONE.
    busy_n = (state == CLEAR) || (state_n == CLEAR);
  end

  always_ff @(posedge i_dotclk or posedge i_reset) begin
    if (i_reset) begin
      state        <= NORMAL;
      cnt          <= '0;
      o_waddr      <= '0;
      o_wdata      <= 1'b0;
      o_wren       <= 1'b0;
      o_ovl_ack    <= 1'b0;
      o_clear_busy <= 1'b0;
      o_clear_done <= 1'b0;
      o_drop_cnt   <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      o_waddr      <= waddr_n;
      o_wdata      <= wdata_n;
      o_wren       <= wren_n;
      o_ovl_ack    <= ack_n;
      o_clear_busy <= busy_n;
      o_clear_done <= done_n;
      if (drop_inc && (o_drop_cnt != '1)) o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter with a shrunken frame buffer for short clear sweeps.
module tb_fb_write_arbiter;
  localparam int AW = 18;
  localparam int FB = 320;
  localparam int DW = 8;

  logic          clk = 1'b0, rst = 1'b0;
  logic          pix_valid = 1'b0, pix_data = 1'b0, clear_req = 1'b0;
  logic          ovl_req = 1'b0, ovl_data = 1'b0;
  logic [AW-1:0] pix_addr = '0, ovl_addr = '0;
  logic          ovl_ack, wdata, wren, clear_busy, clear_done;
  logic [AW-1:0] waddr;
  logic [DW-1:0] drop_cnt;

  always #5 clk = ~clk;

  fb_write_arbiter #(.ADDR_W(AW), .FB_DEPTH(FB), .DROP_W(DW)) dut (
    .i_dotclk(clk), .i_reset(rst),
    .i_pix_valid(pix_valid), .i_pix_addr(pix_addr), .i_pix_data(pix_data),
    .i_clear_req(clear_req),
    .i_ovl_req(ovl_req), .i_ovl_addr(ovl_addr), .i_ovl_data(ovl_data),
    .o_ovl_ack(ovl_ack), .o_waddr(waddr), .o_wdata(wdata), .o_wren(wren),
    .o_clear_busy(clear_busy), .o_clear_done(clear_done), .o_drop_cnt(drop_cnt)
  );

  int          tests = 0, fails = 0;
  logic [AW:0] sb[$];
  logic        prev_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int a, input logic d);
    sb.push_back({AW'(a), d});
  endtask

  task automatic push_sweep(input int last);
    for (int i = 0; i <= last; i++) push(i, 1'b0);
  endtask

  task automatic pix(input logic v, input int a, input logic d);
    pix_valid = v; pix_addr = AW'(a); pix_data = d;
  endtask

  task automatic ovl(input logic r, input int a, input logic d);
    ovl_req = r; ovl_addr = AW'(a); ovl_data = d;
  endtask

  // Monitor: every RAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("ack_back_to_back", {63'b0, ovl_ack & prev_ack}, 64'd0);
      if (wren) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr %0h data %0b, expected no write", waddr, wdata);
        end else begin
          check("write", {waddr, wdata}, sb.pop_front());
        end
      end
    end
    prev_ack <= ovl_ack;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int done_cnt, done_at, ack_at, bad_busy;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wren", wren, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_ack", ovl_ack, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;

    // Capture path, including the last valid and first invalid address.
    pix(1, 'h123, 1); push('h123, 1); @(negedge clk);
    check("pix_wren", wren, 1);
    check("pix_addr", waddr, 'h123);
    pix(1, 5, 0); push(5, 0); @(negedge clk);
    pix(1, FB - 1, 1); push(FB - 1, 1); @(negedge clk);
    pix(1, FB, 1); @(negedge clk);
    check("oob_wren", wren, 0);
    check("oob_hold_addr", waddr, FB - 1);
    check("oob_drop", drop_cnt, 1);
    pix(0, 0, 0); @(negedge clk);
    check("idle_wren", wren, 0);

    // Overlay starved by capture, granted in a single gap.
    ovl(1, 'h20, 1);
    for (int i = 1; i <= 3; i++) begin
      pix(1, i, 1); push(i, 1); @(negedge clk);
      check("ovl_blocked", ovl_ack, 0);
    end
    pix(0, 0, 0); push('h20, 1); @(negedge clk);
    check("ovl_ack", ovl_ack, 1);
    check("ovl_addr", waddr, 'h20);
    ovl(0, 0, 0); pix(1, 4, 0); push(4, 0); @(negedge clk);
    check("ovl_ack_clear", ovl_ack, 0);
    check("capture_resume", waddr, 4);
    pix(0, 0, 0); ovl(1, 'h30, 0); push('h30, 0); @(negedge clk);
    check("ovl_ack2", ovl_ack, 1);
    @(negedge clk);
    check("ovl_no_reack", ovl_ack, 0);
    ovl(0, 0, 0); @(negedge clk);
    ovl(1, 'h200, 1); @(negedge clk);
    check("ovl_oob_ack", ovl_ack, 1);
    check("ovl_oob_wren", wren, 0);
    ovl(0, 0, 0); @(negedge clk);

    // Full clear with a colliding pixel, pixels during sweep, overlay held off.
    clear_req = 1; pix(1, 7, 1); ovl(1, 'h44, 1);
    push_sweep(FB - 1); push('h44, 1);
    done_cnt = 0; done_at = -1; ack_at = -1; bad_busy = 0;
    for (int n = 1; n <= FB + 5; n++) begin
      @(negedge clk);
      clear_req = 0;
      pix(n <= 10, n, 1);
      if (clear_busy !== ((n - 1) <= FB)) bad_busy++;
      if (clear_done) begin done_cnt++; done_at = n - 1; end
      if (ovl_ack) begin ack_at = n - 1; ovl(0, 0, 0); end
    end
    check("clear_busy_span", bad_busy, 0);
    check("clear_done_count", done_cnt, 1);
    check("clear_done_cycle", done_at, FB + 1);
    check("ovl_after_clear", ack_at, FB + 2);
    check("clear_drop", drop_cnt, 12);

    // Restart mid-sweep at count 50.
    clear_req = 1; push_sweep(50); push_sweep(FB - 1);
    done_cnt = 0; done_at = -1;
    for (int n = 1; n <= FB + 60; n++) begin
      @(negedge clk);
      clear_req = (n == 51);
      if (clear_done) begin done_cnt++; done_at = n - 1; end
    end
    check("restart_done_count", done_cnt, 1);
    check("restart_done_cycle", done_at, FB + 52);

    // Clear request landing in DONE: re-sweep, no done between sweeps.
    clear_req = 1; push_sweep(FB - 1); push_sweep(FB - 1);
    done_cnt = 0; done_at = -1;
    for (int n = 1; n <= 2 * FB + 10; n++) begin
      @(negedge clk);
      clear_req = (n == FB + 1);
      if (n == FB + 2) check("busy_through_done", clear_busy, 1);
      if (clear_done) begin done_cnt++; done_at = n - 1; end
    end
    check("redone_count", done_cnt, 1);
    check("redone_cycle", done_at, 2 * FB + 2);

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) begin
      pix(1, FB + i, 1); @(negedge clk);
    end
    pix(0, 0, 0);
    check("drop_saturate", drop_cnt, 255);
    @(negedge clk);

    // Reset in the middle of a sweep.
    clear_req = 1; push_sweep(100);
    for (int n = 1; n <= 102; n++) begin
      @(negedge clk);
      clear_req = 0;
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_wren", wren, 0);
    check("midrst_waddr", waddr, 0);
    check("midrst_busy", clear_busy, 0);
    check("midrst_drop", drop_cnt, 0);
    done_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (clear_done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    pix(1, FB, 1); @(negedge clk);
    check("post_rst_oob_wren", wren, 0);
    check("post_rst_drop", drop_cnt, 1);
    pix(1, 9, 1); push(9, 1); @(negedge clk);
    check("post_rst_normal", waddr, 9);
    pix(0, 0, 0);
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
